// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-timer sequencer. Random wait, lights "go",
// times the response in ms and reports result / false start / timeout.
module reaction_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_RT_MS    = 9999
) (
  input  logic        clk50M,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [11:0] random_num,
  output logic        led,
  output logic        busy,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, REACT = 2'd2, DONE = 2'd3} state_t;

  state_t          state, nxt;
  logic [TW-1:0]   tick_cnt;
  logic [13:0]     ms_cnt;
  logic [12:0]     delay_ms, delay_d, delay_sum;
  logic            tick, clr_cnt;
  logic            led_d, busy_d, rv_d, fs_d, to_d;
  logic [13:0]     res_d;

  // 13-bit sum cannot overflow: MIN_DELAY_MS <= 4096 and random_num <= 4095.
  assign delay_sum = 13'(MIN_DELAY_MS) + {1'b0, random_num};
  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));

  // State, captured delay and all outputs are registered together.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      delay_ms     <= '0;
      led          <= 1'b0;
      busy         <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= nxt;
      delay_ms     <= delay_d;
      led          <= led_d;
      busy         <= busy_d;
      result_ms    <= res_d;
      result_valid <= rv_d;
      false_start  <= fs_d;
      timeout      <= to_d;
    end
  end

  // Next-state and next-output decode; stop beats expiry/timeout, start beats stop.
  always_comb begin
    nxt     = state;
    delay_d = delay_ms;
    led_d   = led;
    busy_d  = busy;
    res_d   = result_ms;
    rv_d    = result_valid;
    fs_d    = false_start;
    to_d    = timeout;
    clr_cnt = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt     = WAIT;
          delay_d = (delay_sum == 13'd0) ? 13'd1 : delay_sum;
          busy_d  = 1'b1;
          led_d   = 1'b0;
          res_d   = '0;
          rv_d    = 1'b0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
          clr_cnt = 1'b1;
        end
      end
      WAIT: begin
        if (stop) begin
          nxt    = DONE;
          fs_d   = 1'b1;
          res_d  = '0;
          led_d  = 1'b0;
          busy_d = 1'b0;
        end else if (tick && ms_cnt == {1'b0, delay_ms - 13'd1}) begin
          nxt     = REACT;
          led_d   = 1'b1;
          clr_cnt = 1'b1;
        end
      end
      REACT: begin
        if (stop) begin
          nxt    = DONE;
          res_d  = ms_cnt;
          rv_d   = 1'b1;
          led_d  = 1'b0;
          busy_d = 1'b0;
        end else if (ms_cnt == 14'(MAX_RT_MS)) begin
          nxt    = DONE;
          res_d  = 14'(MAX_RT_MS);
          to_d   = 1'b1;
          led_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Millisecond timebase; restarts from zero on entry to WAIT and REACT.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (clr_cnt) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (state == WAIT || state == REACT) begin
      if (tick) begin
        tick_cnt <= '0;
        ms_cnt   <= ms_cnt + 14'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: vector table + directed corners + random rounds vs. a
// closed-form model of one round.
module tb_reaction_ctrl;
  localparam int TD  = 4;
  localparam int MIN = 2;
  localparam int MAX = 20;

  logic        clk50M = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [11:0] random_num = '0;
  logic        led, busy, rv, fs, to;
  logic [13:0] result_ms;

  logic        start2 = 1'b0, stop2 = 1'b0;
  logic [11:0] rnd2 = '0;
  logic        led2, busy2, rv2, fs2, to2;
  logic [13:0] res2;

  int n_pass = 0, n_tot = 0;

  reaction_ctrl #(.TICK_DIV(TD), .MIN_DELAY_MS(MIN), .MAX_RT_MS(MAX)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .start(start), .stop(stop), .random_num(random_num),
    .led(led), .busy(busy), .result_ms(result_ms), .result_valid(rv),
    .false_start(fs), .timeout(to));

  reaction_ctrl #(.TICK_DIV(TD), .MIN_DELAY_MS(0), .MAX_RT_MS(MAX)) dut0 (
    .clk50M(clk50M), .rst_n(rst_n), .start(start2), .stop(stop2), .random_num(rnd2),
    .led(led2), .busy(busy2), .result_ms(res2), .result_valid(rv2),
    .false_start(fs2), .timeout(to2));

  always #5 clk50M = ~clk50M;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One round: start sampled at cycle 0; outputs observed at cycle c+1 after edge c.
  task automatic run_round(input int rnd, input int stop_off, input int xstart,
                           input int rnd_after, output int led_c, output int done_c,
                           output int b1, output int excl_bad);
    led_c = -1; done_c = -1; b1 = 0; excl_bad = 0;
    random_num = 12'(rnd);
    for (int c = 0; c < 20000 && done_c < 0; c++) begin
      start = (c == 0) || (c == xstart);
      stop  = (c == stop_off);
      if (c > 0) random_num = 12'(rnd_after);
      @(posedge clk50M); #1;
      start = 1'b0; stop = 1'b0;
      if (c == 0) b1 = int'(busy);
      if (led && led_c < 0) led_c = c + 1;
      if (int'(rv) + int'(fs) + int'(to) > 1) excl_bad = 1;
      if (!busy) done_c = c + 1;
    end
  endtask

  typedef struct {
    int rnd; int stop_off; int xstart; int rnd_after;
    int led; int done; int rv; int fs; int to; int res;
  } vec_t;

  // Closed-form expectation for a round from the timing rules.
  task automatic model(input int rnd, input int stop_off, output vec_t e);
    int d, lr;
    d = MIN + rnd;
    if (d == 0) d = 1;
    lr = 1 + d * TD;
    e.rv = 0; e.fs = 0; e.to = 0;
    if (stop_off >= 1 && stop_off < lr) begin
      e.fs = 1; e.res = 0; e.led = -1; e.done = stop_off + 1;
    end else if (stop_off >= lr && stop_off - lr <= MAX * TD) begin
      e.rv = 1; e.res = (stop_off - lr) / TD; e.led = lr; e.done = stop_off + 1;
    end else begin
      e.to = 1; e.res = MAX; e.led = lr; e.done = lr + MAX * TD + 1;
    end
  endtask

  task automatic check_round(input string tag, input vec_t e, input int led_c,
                             input int done_c, input int excl_bad);
    chk({tag, " led_rise"}, led_c, e.led);
    chk({tag, " done"}, done_c, e.done);
    chk({tag, " result_valid"}, int'(rv), e.rv);
    chk({tag, " false_start"}, int'(fs), e.fs);
    chk({tag, " timeout"}, int'(to), e.to);
    chk({tag, " result_ms"}, int'(result_ms), e.res);
    chk({tag, " exclusive"}, excl_bad, 0);
  endtask

  vec_t tbl[11];

  initial begin
    int lc, dc, b1, xb;
    vec_t e;

    tbl[0]  = '{3,  31, -1, 3,    21, 32,  1, 0, 0, 2};   // normal, stop at REACT idx 10
    tbl[1]  = '{3,   6, -1, 3,    -1, 7,   0, 1, 0, 0};   // false start
    tbl[2]  = '{3,  20, -1, 3,    -1, 21,  0, 1, 0, 0};   // stop in expiry-tick cycle
    tbl[3]  = '{3,  -1, -1, 3,    21, 102, 0, 0, 1, 20};  // timeout
    tbl[4]  = '{3, 101, -1, 3,    21, 102, 1, 0, 0, 20};  // stop when ms_cnt == MAX
    tbl[5]  = '{3, 100, -1, 3,    21, 101, 1, 0, 0, 19};  // one cycle earlier
    tbl[6]  = '{3,  -1,  5, 4000, 21, 102, 0, 0, 1, 20};  // start in WAIT, rnd changes
    tbl[7]  = '{3,  -1, 40, 4000, 21, 102, 0, 0, 1, 20};  // start in REACT
    tbl[8]  = '{3,   0, -1, 3,    21, 102, 0, 0, 1, 20};  // start+stop together
    tbl[9]  = '{3,  21, -1, 3,    21, 22,  1, 0, 0, 0};   // stop on first REACT cycle
    tbl[10] = '{0,  12, -1, 0,    9,  13,  1, 0, 0, 0};   // zero random, k=3

    // Reset held: inputs toggling must not move outputs.
    for (int i = 0; i < 4; i++) begin
      start = i[0]; stop = ~i[0]; random_num = 12'($urandom);
      @(posedge clk50M); #1;
      chk("reset_hold outputs", int'({led, busy, rv, fs, to, result_ms}), 0);
    end
    start = 1'b0; stop = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk50M);
    #1;
    chk("idle_after_reset outputs", int'({led, busy, rv, fs, to, result_ms}), 0);

    for (int i = 0; i < 11; i++) begin
      run_round(tbl[i].rnd, tbl[i].stop_off, tbl[i].xstart, tbl[i].rnd_after, lc, dc, b1, xb);
      chk($sformatf("vec%0d busy_c1", i), b1, 1);
      check_round($sformatf("vec%0d", i), tbl[i], lc, dc, xb);
      repeat (2) @(posedge clk50M);
      #1;
    end

    // Zero-sum delay forced to 1 ms on the MIN_DELAY_MS=0 instance.
    begin
      int l2 = -1;
      start2 = 1'b1;
      for (int c = 0; c < 40 && l2 < 0; c++) begin
        @(posedge clk50M); #1;
        start2 = 1'b0;
        if (led2) l2 = c + 1;
      end
      chk("min0 led_rise", l2, 5);
    end

    // stop pulses in DONE are ignored.
    run_round(3, 31, -1, 3, lc, dc, b1, xb);
    stop = 1'b1; @(posedge clk50M); #1; stop = 1'b0;
    repeat (3) @(posedge clk50M);
    #1;
    chk("done_stop_ignored result_ms", int'(result_ms), 2);
    chk("done_stop_ignored result_valid", int'(rv), 1);
    chk("done_stop_ignored busy", int'(busy), 0);

    // Reset mid-REACT: outputs drop without a clock edge.
    random_num = 12'd3; start = 1'b1;
    @(posedge clk50M); #1; start = 1'b0;
    repeat (25) @(posedge clk50M);
    #1;
    chk("midreset led_before", int'(led), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset async outputs", int'({led, busy, rv, fs, to, result_ms}), 0);
    @(posedge clk50M); #1 rst_n = 1'b1;
    @(posedge clk50M); #1;
    run_round(3, 31, -1, 3, lc, dc, b1, xb);
    check_round("after_reset", tbl[0], lc, dc, xb);

    // Random rounds against the closed-form model.
    for (int r = 0; r < 30; r++) begin
      int rnd, so, xs, lr;
      rnd = int'($urandom_range(0, 15));
      lr  = 1 + (MIN + rnd) * TD;
      so  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, lr + 90));
      xs  = int'($urandom_range(1, lr + 60));
      model(rnd, so, e);
      run_round(rnd, so, xs, int'($urandom_range(0, 4095)), lc, dc, b1, xb);
      check_round($sformatf("rand%0d", r), e, lc, dc, xb);
      repeat (int'($urandom_range(0, 3))) @(posedge clk50M);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
